// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32I decode stage and ID/EX pipeline register.
// Holds the control decoder, immediate extender, a register file with
// same-cycle write-through bypass, load-use hazard detection with automatic
// bubble insertion, and flush/stall handling for the E-stage register.
// Optional build macro DECODE_ILLEGAL_TRAP_EN adds the registered IllegalE
// output, which marks valid slots that carry an unsupported opcode.
module decode_stage_pipe #(
    parameter int               WIDTH    = 32,
    parameter int               NUM_REGS = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    localparam int              AW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      InstrD,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic             ValidD,
    input  logic             RegWriteW,
    input  logic [AW-1:0]    RdW,
    input  logic [WIDTH-1:0] ResultW,
    input  logic             FlushE,
    output logic             HazardStall,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic             JALRctrlE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] ImmExtE,
    output logic [WIDTH-1:0] PCE,
    output logic [WIDTH-1:0] PCPlus4E,
    output logic [AW-1:0]    Rs1E,
    output logic [AW-1:0]    Rs2E,
    output logic [AW-1:0]    RdE,
    output logic             ValidE,
    output logic [WIDTH-1:0] a0
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic             IllegalE
`endif
);

    // Supported major opcodes
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // ALU operation encodings seen by the execute stage
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux selections
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_e;

    // Sign-extend a 32-bit immediate to the datapath width
    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] value);
        return WIDTH'($signed(value));
    endfunction

    // Instruction fields
    logic [6:0]    opcode_s;
    logic [2:0]    funct3_s;
    logic          funct7b5_s;
    logic [AW-1:0] rs1_s;
    logic [AW-1:0] rs2_s;
    logic [AW-1:0] rd_s;

    assign opcode_s   = InstrD[6:0];
    assign funct3_s   = InstrD[14:12];
    assign funct7b5_s = InstrD[30];
    assign rs1_s      = InstrD[15 +: AW];
    assign rs2_s      = InstrD[20 +: AW];
    assign rd_s       = InstrD[7 +: AW];

    // Decoded controls
    logic       reg_write_s;
    logic       mem_write_s;
    logic       jump_s;
    logic       branch_s;
    logic       alu_src_s;
    logic       jalr_ctrl_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_op_s;
    logic [2:0] alu_control_s;
    imm_sel_e   imm_src_s;
    logic       supported_s;
    logic       rs2_used_s;

    // Main control decoder: unsupported opcodes keep every control at zero
    always_comb begin
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        jump_s       = 1'b0;
        branch_s     = 1'b0;
        alu_src_s    = 1'b0;
        jalr_ctrl_s  = 1'b0;
        result_src_s = RES_ALU;
        alu_op_s     = 2'b00;
        imm_src_s    = IMM_I;
        supported_s  = 1'b1;
        rs2_used_s   = 1'b0;
        case (opcode_s)
            OP_LW: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = RES_MEM;
            end
            OP_SW: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_src_s   = IMM_S;
                rs2_used_s  = 1'b1;
            end
            OP_R: begin
                reg_write_s = 1'b1;
                alu_op_s    = 2'b10;
                rs2_used_s  = 1'b1;
            end
            OP_IALU: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                alu_op_s    = 2'b10;
            end
            OP_BEQ: begin
                branch_s   = 1'b1;
                alu_op_s   = 2'b01;
                imm_src_s  = IMM_B;
                rs2_used_s = 1'b1;
            end
            OP_JAL: begin
                reg_write_s  = 1'b1;
                jump_s       = 1'b1;
                result_src_s = RES_PC4;
                imm_src_s    = IMM_J;
            end
            OP_JALR: begin
                reg_write_s  = 1'b1;
                jump_s       = 1'b1;
                jalr_ctrl_s  = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = RES_PC4;
            end
            OP_LUI: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_src_s   = IMM_U;
            end
            default: begin
                supported_s = 1'b0;
            end
        endcase
    end

    // ALU decoder: memory ops add, branches subtract, ALU ops use funct3/funct7
    always_comb begin
        alu_control_s = ALU_ADD;
        case (alu_op_s)
            2'b00: alu_control_s = ALU_ADD;
            2'b01: alu_control_s = ALU_SUB;
            2'b10: begin
                case (funct3_s)
                    3'b000: begin
                        // Only register-register forms can subtract; addi
                        // reuses bit 30 as part of its immediate.
                        if (opcode_s[5] && funct7b5_s) begin
                            alu_control_s = ALU_SUB;
                        end else begin
                            alu_control_s = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control_s = ALU_SLT;
                    3'b110:  alu_control_s = ALU_OR;
                    3'b111:  alu_control_s = ALU_AND;
                    default: alu_control_s = ALU_ADD;
                endcase
            end
            default: alu_control_s = ALU_ADD;
        endcase
    end

    // Immediate extender: build each format at 32 bits, then sign-extend
    logic [31:0]      imm32_s;
    logic [WIDTH-1:0] imm_ext_s;

    // Select and assemble the immediate for the decoded format
    always_comb begin
        imm32_s = 32'd0;
        case (imm_src_s)
            IMM_I:   imm32_s = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm32_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm32_s = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                                InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   imm32_s = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                InstrD[20], InstrD[30:21], 1'b0};
            IMM_U:   imm32_s = {InstrD[31:12], 12'd0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm_ext_s = sext32(imm32_s);

    // Register file
    logic [WIDTH-1:0] regs_r [NUM_REGS];
    logic             wb_en_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    assign wb_en_s = RegWriteW && (RdW != {AW{1'b0}});

    // Register file write port; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wb_en_s) begin
            regs_r[RdW] <= ResultW;
        end
    end

    // Read port 1 with x0 forced to zero and same-cycle writeback bypass
    always_comb begin
        rd1_s = {WIDTH{1'b0}};
        if (rs1_s == {AW{1'b0}}) begin
            rd1_s = {WIDTH{1'b0}};
        end else if (wb_en_s && (RdW == rs1_s)) begin
            rd1_s = ResultW;
        end else begin
            rd1_s = regs_r[rs1_s];
        end
    end

    // Read port 2 with x0 forced to zero and same-cycle writeback bypass
    always_comb begin
        rd2_s = {WIDTH{1'b0}};
        if (rs2_s == {AW{1'b0}}) begin
            rd2_s = {WIDTH{1'b0}};
        end else if (wb_en_s && (RdW == rs2_s)) begin
            rd2_s = ResultW;
        end else begin
            rd2_s = regs_r[rs2_s];
        end
    end

    assign a0 = regs_r[10];

    // Load-use hazard: a valid load in E whose destination feeds this instruction
    assign HazardStall = ValidE && (ResultSrcE == RES_MEM) && (RdE != {AW{1'b0}})
                         && ((RdE == rs1_s) || ((RdE == rs2_s) && rs2_used_s));

    // A slot becomes a bubble on flush, on stall, when no real instruction is
    // offered, or (without the trap feature) when the opcode is unsupported.
    logic bubble_s;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bubble_s = FlushE || HazardStall || !ValidD;
`else
    assign bubble_s = FlushE || HazardStall || !ValidD || !supported_s;
`endif

    // ID/EX register: bubbles clear controls and hold the data fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            JALRctrlE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= {WIDTH{1'b0}};
            RD2E        <= {WIDTH{1'b0}};
            ImmExtE     <= {WIDTH{1'b0}};
            PCE         <= RESET_PC;
            PCPlus4E    <= {WIDTH{1'b0}};
            Rs1E        <= {AW{1'b0}};
            Rs2E        <= {AW{1'b0}};
            RdE         <= {AW{1'b0}};
            ValidE      <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= 1'b0;
`endif
        end else if (bubble_s) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            JALRctrlE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            ValidE      <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= 1'b0;
`endif
        end else begin
            RegWriteE   <= reg_write_s;
            MemWriteE   <= mem_write_s;
            JumpE       <= jump_s;
            BranchE     <= branch_s;
            ALUSrcE     <= alu_src_s;
            JALRctrlE   <= jalr_ctrl_s;
            ResultSrcE  <= result_src_s;
            ALUControlE <= alu_control_s;
            RD1E        <= rd1_s;
            RD2E        <= rd2_s;
            ImmExtE     <= imm_ext_s;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= rs1_s;
            Rs2E        <= rs2_s;
            RdE         <= rd_s;
            ValidE      <= ValidD;
`ifdef DECODE_ILLEGAL_TRAP_EN
            IllegalE    <= !supported_s;
`endif
        end
    end

endmodule
